// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around an eight-bit ALU: takes one command at a time over valid/ready,
// evaluates it, and presents a registered result; an accumulator lets ops chain on the last result.
module alu_cmd_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [3:0]            cmd_func_i,
   input  logic [DATA_WIDTH-1:0] cmd_a_i,
   input  logic [DATA_WIDTH-1:0] cmd_b_i,
   input  logic                  cmd_use_acc_i,
   input  logic                  acc_clear_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [DATA_WIDTH-1:0] res_data_o,
   output logic [3:0]            res_func_o,
   output logic [DATA_WIDTH-1:0] acc_o,
   output logic [CNT_WIDTH-1:0]  ops_done_o
);

   localparam logic [3:0] FUNC_ALL_ZERO        = 4'd0;
   localparam logic [3:0] FUNC_ALL_ONE         = 4'd1;
   localparam logic [3:0] FUNC_OUTPUT_A        = 4'd2;
   localparam logic [3:0] FUNC_OUTPUT_B        = 4'd3;
   localparam logic [3:0] FUNC_NOT_A           = 4'd4;
   localparam logic [3:0] FUNC_NOT_B           = 4'd5;
   localparam logic [3:0] FUNC_A_AND_B         = 4'd6;
   localparam logic [3:0] FUNC_A_OR_B          = 4'd7;
   localparam logic [3:0] FUNC_A_XOR_B         = 4'd8;
   localparam logic [3:0] FUNC_OUTPUT_A_PLUS_B = 4'd9;
   localparam logic [3:0] FUNC_OUTPUT_A_MINUS_B = 4'd10;
   localparam logic [3:0] FUNC_OUTPUT_B_MINUS_A = 4'd11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]            state;
   logic [3:0]            op_func_p0;
   logic [DATA_WIDTH-1:0] op_a_p0;
   logic [DATA_WIDTH-1:0] op_b_p0;
   logic [DATA_WIDTH-1:0] alu_y;

   // Combinational ALU; arithmetic wraps at DATA_WIDTH, unassigned codes yield zero.
   function automatic logic [DATA_WIDTH-1:0] eight_bit_alu(input logic [3:0]            func,
                                                           input logic [DATA_WIDTH-1:0] a,
                                                           input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] y;
      y = '0;
      case (func)
         FUNC_ALL_ZERO:         y = '0;
         FUNC_ALL_ONE:          y = '1;
         FUNC_OUTPUT_A:         y = a;
         FUNC_OUTPUT_B:         y = b;
         FUNC_NOT_A:            y = ~a;
         FUNC_NOT_B:            y = ~b;
         FUNC_A_AND_B:          y = a & b;
         FUNC_A_OR_B:           y = a | b;
         FUNC_A_XOR_B:          y = a ^ b;
         FUNC_OUTPUT_A_PLUS_B:  y = a + b;
         FUNC_OUTPUT_A_MINUS_B: y = a - b;
         FUNC_OUTPUT_B_MINUS_A: y = b - a;
         default:               y = '0;
      endcase
      return y;
   endfunction

   assign alu_y       = eight_bit_alu(op_func_p0, op_a_p0, op_b_p0);
   assign cmd_ready_o = (state == ST_IDLE) && !rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         op_func_p0  <= '0;
         op_a_p0     <= '0;
         op_b_p0     <= '0;
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         res_func_o  <= '0;
         acc_o       <= '0;
         ops_done_o  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  op_func_p0 <= cmd_func_i;
                  op_a_p0    <= cmd_use_acc_i ? acc_o : cmd_a_i;
                  op_b_p0    <= cmd_b_i;
                  state      <= ST_EXEC;
               end
            end
            // EXEC -> HOLD: register the ALU output as the result
            ST_EXEC: begin
               res_data_o  <= alu_y;
               res_func_o  <= op_func_p0;
               res_valid_o <= 1'b1;
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  ops_done_o  <= ops_done_o + 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // A clear on the capture edge overrides the new result.
         if (acc_clear_i) begin
            acc_o <= '0;
         end else if (state == ST_EXEC) begin
            acc_o <= alu_y;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer against an arithmetic reference model.
module tb_alu_cmd_sequencer;

   localparam logic [3:0] F_ALL_ZERO  = 4'd0;
   localparam logic [3:0] F_ALL_ONE   = 4'd1;
   localparam logic [3:0] F_OUT_A     = 4'd2;
   localparam logic [3:0] F_OUT_B     = 4'd3;
   localparam logic [3:0] F_NOT_A     = 4'd4;
   localparam logic [3:0] F_NOT_B     = 4'd5;
   localparam logic [3:0] F_AND       = 4'd6;
   localparam logic [3:0] F_OR        = 4'd7;
   localparam logic [3:0] F_XOR       = 4'd8;
   localparam logic [3:0] F_PLUS      = 4'd9;
   localparam logic [3:0] F_A_MINUS_B = 4'd10;
   localparam logic [3:0] F_B_MINUS_A = 4'd11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_func = '0;
   logic [7:0] cmd_a = '0;
   logic [7:0] cmd_b = '0;
   logic       cmd_use_acc = 1'b0;
   logic       acc_clear = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [3:0] res_func;
   logic [7:0] acc;
   logic [7:0] ops_done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] acc_m = '0;
   int ops_m = 0;

   alu_cmd_sequencer #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_func_i(cmd_func), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
      .cmd_use_acc_i(cmd_use_acc), .acc_clear_i(acc_clear),
      .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_data_o(res_data), .res_func_o(res_func),
      .acc_o(acc), .ops_done_o(ops_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      int ia, ib, r;
      ia = a; ib = b; r = 0;
      case (f)
         F_ALL_ZERO:  r = 0;
         F_ALL_ONE:   r = 255;
         F_OUT_A:     r = ia;
         F_OUT_B:     r = ib;
         F_NOT_A:     r = 255 - ia;
         F_NOT_B:     r = 255 - ib;
         F_AND:       r = int'(a & b);
         F_OR:        r = int'(a | b);
         F_XOR:       r = int'(a ^ b);
         F_PLUS:      r = (ia + ib) % 256;
         F_A_MINUS_B: r = (ia - ib + 256) % 256;
         F_B_MINUS_A: r = (ib - ia + 256) % 256;
         default:     r = 0;
      endcase
      return r[7:0];
   endfunction

   // One complete transaction with inline checks at every phase.
   task automatic run_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, input bit clr_acc, input bit clr_cap,
                         input int hold, input bit poke);
      logic [7:0] exp_y;
      int guard;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 10) begin
         @(posedge clk); #1; guard++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_wait: cmd_ready=%b required 1", cmd_ready); end
      exp_y = alu_ref(f, ua ? acc_m : a, b);
      cmd_valid = 1'b1; cmd_func = f; cmd_a = a; cmd_b = b; cmd_use_acc = ua; acc_clear = clr_acc;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_use_acc = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      cmd_func = 4'($urandom); acc_clear = clr_cap;
      if (clr_acc) acc_m = '0;
      n_checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL exec_phase: res_valid=%b cmd_ready=%b required 0 0", res_valid, cmd_ready);
      end
      n_checks++;
      if (acc !== acc_m) begin n_fail++; $display("FAIL exec_acc: acc=%h required %h", acc, acc_m); end
      @(posedge clk); #1;
      acc_clear = 1'b0;
      acc_m = clr_cap ? 8'h00 : exp_y;
      n_checks++;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL latency: res_valid=%b required 1", res_valid); end
      n_checks++;
      if (res_data !== exp_y) begin n_fail++; $display("FAIL res_data f=%0d: got %h required %h", f, res_data, exp_y); end
      n_checks++;
      if (res_func !== f) begin n_fail++; $display("FAIL res_func: got %0d required %0d", res_func, f); end
      n_checks++;
      if (acc !== acc_m) begin n_fail++; $display("FAIL acc_capture: acc=%h required %h", acc, acc_m); end
      if (poke) begin
         cmd_valid = 1'b1; cmd_func = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (res_valid !== 1'b1 || res_data !== exp_y || res_func !== f || cmd_ready !== 1'b0 ||
             ops_done !== 8'(ops_m)) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%b data=%h func=%0d ready=%b ops=%0d required 1 %h %0d 0 %0d",
                     res_valid, res_data, res_func, cmd_ready, ops_done, exp_y, f, ops_m);
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0; cmd_valid = 1'b0;
      ops_m = (ops_m + 1) % 256;
      n_checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL handoff: res_valid=%b cmd_ready=%b required 0 1", res_valid, cmd_ready);
      end
      n_checks++;
      if (ops_done !== 8'(ops_m)) begin n_fail++; $display("FAIL ops_done: got %0d required %0d", ops_done, ops_m); end
   endtask

   task automatic test_reset;
      #2;
      n_checks++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || res_func !== 4'h0 || acc !== 8'h00 ||
          ops_done !== 8'h00 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: valid=%b data=%h func=%0d acc=%h ops=%0d ready=%b required all 0",
                            res_valid, res_data, res_func, acc, ops_done, cmd_ready);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
      cmd_valid = 1'b1; cmd_func = F_PLUS; cmd_a = 8'd3; cmd_b = 8'd4;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 8'd7 || acc !== 8'd7) begin
         n_fail++; $display("FAIL pre_reset_op: valid=%b data=%h acc=%h required 1 07 07", res_valid, res_data, acc);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || res_data !== 8'h00 || res_func !== 4'h0 || acc !== 8'h00 ||
          ops_done !== 8'h00 || cmd_ready !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: valid=%b data=%h func=%0d acc=%h ops=%0d ready=%b required all 0",
                            res_valid, res_data, res_func, acc, ops_done, cmd_ready);
      end
      @(negedge clk); rst = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b required 1", cmd_ready); end
      @(posedge clk); #1;
      acc_m = '0; ops_m = 0;
   endtask

   task automatic test_basic;
      run_op(F_B_MINUS_A, 8'd5, 8'd10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_wrap_arith;
      run_op(F_PLUS, 8'd255, 8'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(F_B_MINUS_A, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(F_B_MINUS_A, 8'd255, 8'd50, 1'b0, 1'b0, 1'b0, 1, 1'b0);
   endtask

   task automatic test_chain;
      run_op(F_PLUS, 8'd100, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(F_PLUS, 8'($urandom), 8'd50, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      run_op(F_XOR, 8'($urandom), 8'hFF, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      n_checks++;
      if (acc !== 8'h69) begin n_fail++; $display("FAIL chain_final_acc: got %h required 69", acc); end
   endtask

   task automatic test_backpressure;
      int ops_before;
      run_op(F_AND, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 5, 1'b1);
      ops_before = ops_m;
      @(posedge clk); #1;
      n_checks++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || ops_done !== 8'(ops_before)) begin
         n_fail++; $display("FAIL no_extra_accept: valid=%b ready=%b ops=%0d required 0 1 %0d",
                            res_valid, cmd_ready, ops_done, ops_before);
      end
   endtask

   task automatic test_acc_clear;
      run_op(F_PLUS, 8'd20, 8'd22, 1'b0, 1'b0, 1'b1, 0, 1'b0);
      run_op(F_OUT_A, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
      run_op(F_PLUS, 8'd0, 8'd1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_in_exec;
      cmd_valid = 1'b1; cmd_func = F_OR; cmd_a = 8'h12; cmd_b = 8'h40;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || acc !== 8'h00 || ops_done !== 8'h00) begin
         n_fail++; $display("FAIL reset_exec: valid=%b acc=%h ops=%0d required 0 00 0", res_valid, acc, ops_done);
      end
      @(negedge clk); rst = 1'b0;
      acc_m = '0; ops_m = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (res_valid !== 1'b0 || ops_done !== 8'h00 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_exec_after: valid=%b ops=%0d ready=%b required 0 0 1",
                               res_valid, ops_done, cmd_ready);
         end
      end
   endtask

   task automatic test_random_counter_wrap;
      for (int k = 0; k < 256; k++) begin
         run_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                $urandom_range(0, 2), 1'($urandom));
      end
      n_checks++;
      if (ops_done !== 8'h00) begin n_fail++; $display("FAIL counter_wrap: got %0d required 0", ops_done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap_arith();
      test_chain();
      test_backpressure();
      test_acc_clear();
      test_reset_in_exec();
      test_random_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
